// File: rtl/crossbar_pkg.sv
// Shared crossbar sizing: slave count, destination width and index helper.
package crossbar_pkg;

  localparam int N_SLAVES = 2;
  localparam int DEST_W   = 2;

  typedef logic [DEST_W-1:0] dest_t;

  // Width of a slave index; a single-slave crossbar still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority search: first requester after last_grant, wrapping modulo N_SLAVES.
// Latency: purely combinational. Backpressure: none, pure function of its inputs.
module rr_pick #(
  parameter int N_SLAVES = 2,
  parameter int IDX_W    = 1
) (
  input  logic [N_SLAVES-1:0] req,
  input  logic [IDX_W-1:0]    last_grant,
  output logic                found,
  output logic [IDX_W-1:0]    idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Offset 1 is highest priority; offset N_SLAVES comes back to last_grant itself.
    for (int k = 1; k <= N_SLAVES; k++) begin
      int j;
      j = (int'(last_grant) + k) % N_SLAVES;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/round_robin.sv
// Per-master-port round-robin arbiter; locks the winning slave for a whole packet.
// Latency: zero-cycle grant and ready; lock taken and released on clock edges.
// Backpressure: s_ready_o mirrors m_ready onto the granted slave only, zero otherwise.
module round_robin #(
  parameter int N_SLAVES = crossbar_pkg::N_SLAVES,
  parameter int DEST_W   = crossbar_pkg::DEST_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DEST_W-1:0]   number,
  input  logic                m_ready,
  input  logic [DEST_W-1:0]   s_dest_i [N_SLAVES],
  input  logic [N_SLAVES-1:0] s_valid_i,
  input  logic                s_last,
  output logic [N_SLAVES-1:0] s_ready_o
);

  import crossbar_pkg::*;

  localparam int IDX_W = idx_w(N_SLAVES);

  logic [N_SLAVES-1:0] req;
  logic                busy;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    last_grant;
  logic                cand_found;
  logic [IDX_W-1:0]    cand;
  logic                grant_vld;
  logic [IDX_W-1:0]    grant;
  logic                hs;
  logic                release_beat;

  always_comb begin
    for (int i = 0; i < N_SLAVES; i++) begin
      req[i] = s_valid_i[i] && (s_dest_i[i] == number);
    end
  end

  rr_pick #(
    .N_SLAVES (N_SLAVES),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .found      (cand_found),
    .idx        (cand)
  );

  // While locked, the search result is ignored so other slaves and the owner's
  // destination changes cannot disturb the packet in flight.
  assign grant_vld = busy || cand_found;
  assign grant     = busy ? owner : cand;

  always_comb begin
    s_ready_o = '0;
    if (!rst && grant_vld) begin
      s_ready_o[grant] = m_ready;
    end
  end

  assign hs           = grant_vld && s_valid_i[grant] && s_ready_o[grant];
  assign release_beat = hs && s_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      owner      <= '0;
      last_grant <= IDX_W'(N_SLAVES - 1);
    end else if (!busy) begin
      if (cand_found) begin
        last_grant <= cand;
        // A single-beat packet completes in the grant cycle and never locks;
        // otherwise the lock is taken even if the master stalled this cycle.
        if (!release_beat) begin
          busy  <= 1'b1;
          owner <= cand;
        end
      end
    end else if (release_beat) begin
      busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_round_robin.sv
// Directed test-plan scenarios plus randomized traffic against a packet-level reference model.
module tb_round_robin;

  localparam int N = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [1:0]                 number;
  logic                       m_ready;
  crossbar_pkg::dest_t        s_dest_i [N];
  logic [N-1:0]               s_valid_i;
  logic                       s_last;
  logic [N-1:0]               s_ready_o;

  int checks = 0;
  int errors = 0;

  // Reference model: which slave holds the port (-1 = free) and who won last.
  int mdl_owner;
  int mdl_last;

  round_robin dut (
    .clk       (clk),
    .rst       (rst),
    .number    (number),
    .m_ready   (m_ready),
    .s_dest_i  (s_dest_i),
    .s_valid_i (s_valid_i),
    .s_last    (s_last),
    .s_ready_o (s_ready_o)
  );

  always #5 clk = ~clk;

  function automatic bit wants(input int j);
    return s_valid_i[j] && (s_dest_i[j] == number);
  endfunction

  // Winner under round-robin: first requester counting onward from the last winner.
  function automatic int model_pick();
    for (int k = 1; k <= N; k++) begin
      if (wants((mdl_last + k) % N)) return (mdl_last + k) % N;
    end
    return -1;
  endfunction

  function automatic int model_grant();
    return (mdl_owner >= 0) ? mdl_owner : model_pick();
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (!rst && g >= 0) r[g] = m_ready;
    return r;
  endfunction

  // Advance one clock; the model takes its next state from the inputs held across the edge.
  task automatic tick();
    int g, nxt_owner, nxt_last;
    bit beat_done;
    g         = model_grant();
    nxt_owner = mdl_owner;
    nxt_last  = mdl_last;
    beat_done = (g >= 0) && m_ready && s_valid_i[g] && s_last;
    if (rst) begin
      nxt_owner = -1;
      nxt_last  = N - 1;
    end else if (g >= 0) begin
      nxt_last  = g;
      nxt_owner = beat_done ? -1 : g;
    end
    @(posedge clk);
    mdl_owner = nxt_owner;
    mdl_last  = nxt_last;
    #1;
  endtask

  task automatic clear_inputs();
    s_valid_i   = '0;
    s_last      = 1'b0;
    s_dest_i[0] = 2'd0;
    s_dest_i[1] = 2'd0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    number  = 2'd0;
    m_ready = 1'b1;
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      if (c == 2) rst = 1'b0;
      #2;
      checks++;
      if (s_ready_o !== 2'b00) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: s_ready_o=%b expected 00", c, s_ready_o);
      end
      tick();
    end
  endtask

  task automatic test_lock();
    number = 2'd0; m_ready = 1'b1;
    s_valid_i = 2'b01; s_dest_i[0] = 2'd0;
    #2; checks++;
    if (s_ready_o !== 2'b01) begin errors++; $display("FAIL lock_first_grant: s_ready_o=%b expected 01", s_ready_o); end
    tick();
    s_valid_i = 2'b11; s_dest_i[1] = 2'd0;
    #2; checks++;
    if (s_ready_o !== 2'b01) begin errors++; $display("FAIL lock_hold: s_ready_o=%b expected 01", s_ready_o); end
    s_last = 1'b1;
    tick();
    s_last = 1'b0; s_valid_i = 2'b10;
    #2; checks++;
    if (s_ready_o !== 2'b10) begin errors++; $display("FAIL lock_handover: s_ready_o=%b expected 10", s_ready_o); end
    tick();
    s_last = 1'b1;
    tick();
    clear_inputs();
    #2; checks++;
    if (s_ready_o !== 2'b00) begin errors++; $display("FAIL lock_released_idle: s_ready_o=%b expected 00", s_ready_o); end
    tick();
  endtask

  task automatic test_fairness();
    number = 2'd0; m_ready = 1'b1;
    s_valid_i = 2'b11;
    #2; checks++;
    if (s_ready_o !== 2'b01) begin errors++; $display("FAIL fair_slave0_first: s_ready_o=%b expected 01", s_ready_o); end
    tick();
    s_last = 1'b1;
    tick();
    s_last = 1'b0;
    #2; checks++;
    if (s_ready_o !== 2'b10) begin errors++; $display("FAIL fair_slave1_next: s_ready_o=%b expected 10", s_ready_o); end
    s_last = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_dest_filter();
    number = 2'd1; m_ready = 1'b1;
    s_valid_i = 2'b11; s_dest_i[0] = 2'd0; s_dest_i[1] = 2'd1;
    #2; checks++;
    if (s_ready_o !== 2'b10) begin errors++; $display("FAIL dest_filter: s_ready_o=%b expected 10", s_ready_o); end
    tick();
    // Owner's destination moving away must not break the lock.
    s_dest_i[1] = 2'd3; s_dest_i[0] = 2'd1;
    #2; checks++;
    if (s_ready_o !== 2'b10) begin errors++; $display("FAIL dest_change_ignored: s_ready_o=%b expected 10", s_ready_o); end
    s_last = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    number = 2'd0; m_ready = 1'b0;
    s_valid_i = 2'b01;
    #2; checks++;
    if (s_ready_o !== 2'b00) begin errors++; $display("FAIL bp_stalled: s_ready_o=%b expected 00", s_ready_o); end
    tick();
    s_valid_i = 2'b11; s_last = 1'b1;
    tick();
    m_ready = 1'b1; s_last = 1'b0;
    #2; checks++;
    if (s_ready_o !== 2'b01) begin errors++; $display("FAIL bp_lock_kept: s_ready_o=%b expected 01", s_ready_o); end
    s_last = 1'b1;
    tick();
    s_last = 1'b0;
    #2; checks++;
    if (s_ready_o !== 2'b10) begin errors++; $display("FAIL bp_release_handover: s_ready_o=%b expected 10", s_ready_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    // Slave 1 holds the port from the previous scenario.
    rst = 1'b1;
    #2; checks++;
    if (s_ready_o !== 2'b00) begin errors++; $display("FAIL reset_mid_ready: s_ready_o=%b expected 00", s_ready_o); end
    tick();
    rst = 1'b0; s_valid_i = 2'b11;
    #2; checks++;
    if (s_ready_o !== 2'b01) begin errors++; $display("FAIL reset_mid_priority: s_ready_o=%b expected 01", s_ready_o); end
    s_last = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] exp;
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 0) number = 2'($urandom_range(0, 1));
      rst         = ($urandom_range(0, 49) == 0);
      m_ready     = ($urandom_range(0, 3) != 0);
      s_valid_i   = N'($urandom);
      s_dest_i[0] = 2'($urandom_range(0, 2));
      s_dest_i[1] = 2'($urandom_range(0, 2));
      s_last      = ($urandom_range(0, 3) == 0);
      #2;
      exp = model_ready();
      checks++;
      if (s_ready_o !== exp) begin
        errors++;
        $display("FAIL random cycle %0d: s_ready_o=%b expected %b (valid=%b d0=%0d d1=%0d num=%0d mr=%b rst=%b)",
                 c, s_ready_o, exp, s_valid_i, s_dest_i[0], s_dest_i[1], number, m_ready, rst);
      end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    mdl_owner = -1;
    mdl_last  = N - 1;
    #1;
    test_reset();
    test_lock();
    test_fairness();
    test_dest_filter();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_robin.md
Name: round_robin

Overview:
- Per-master output arbiter for the crossbar: one instance per master port.
- Selects which slave-side input stream owns this master port, using round-robin priority among slaves whose destination equals this port's index.
- Holds ownership for a whole packet, until the last-beat handshake.
- Drives per-slave ready back-pressure.

Parameters:
- N_SLAVES, 2, number of slave-side input streams competing for this master port.
- DEST_W, 2, width of destination ID and of the port index `number`.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- number  input  DEST_W  static index of the master port this arbiter serves.
- m_ready  input  1  downstream master accepts a beat this cycle.
- s_dest_i  input  N_SLAVES x DEST_W (unpacked array)  destination ID of each slave's current beat.
- s_valid_i  input  N_SLAVES  per-slave beat valid.
- s_last  input  1  last beat of the packet, as muxed from the currently granted slave.
- s_ready_o  output  N_SLAVES  per-slave ready; one-hot or zero.

Behaviour:
- Request vector: req[i] = s_valid_i[i] && (s_dest_i[i] == number).
- State registers:
  - busy (1 bit).
  - owner (index of the locked slave).
  - last_grant (index of the most recently granted slave).
- Reset (rst=1 at a clock edge): busy=0, owner=0, last_grant=N_SLAVES-1, so slave 0 has highest priority first. While rst=1, s_ready_o=0.
- Candidate selection (combinational): the first i with req[i]=1, searching last_grant+1, last_grant+2, ... modulo N_SLAVES. With wrap-around, every slave is reached within N_SLAVES arbitrations.
- Grant:
  - If busy, grant=owner.
  - Else if any req, grant=candidate, with zero latency in the same cycle.
  - Else no grant.
- s_ready_o[grant] = m_ready when a grant exists; all other bits 0. s_ready_o is combinational from m_ready, with no added cycle.
- Beat handshake: hs = s_valid_i[grant] && s_ready_o[grant].
- Idle with grant, at the clock edge:
  - If hs && s_last: single-beat packet. busy stays 0; last_grant <= candidate.
  - Otherwise: busy <= 1; owner <= candidate; last_grant <= candidate. The lock is taken even if m_ready=0 in that cycle.
- Busy, at the clock edge:
  - If hs && s_last: busy <= 0; the next cycle re-arbitrates.
  - Otherwise hold.
- While busy:
  - Requests from other slaves are ignored.
  - Changes on the owner's s_dest_i are ignored.
  - If the owner drops s_valid_i without s_last, the lock holds until a valid last beat.
- s_last is ignored when there is no handshake, i.e. when m_ready=0 or the granted valid is 0.
- Simultaneous requests when idle: the round-robin order decides. Example, N=2, after slave 1 finished: slave 0 wins.
- A new packet on the same port may be granted in the cycle right after a last-beat handshake. There is no bubble beyond the release edge.
- Reset mid-packet drops the lock immediately; s_ready_o=0 in that cycle.

Decomposition:
- Shared package crossbar_pkg holds N_SLAVES, DEST_W, and the dest_t typedef (logic [DEST_W-1:0]).
- One sub-module, rr_pick: a pure combinational rotate-priority search. Inputs: req vector and last_grant. Outputs: a found flag and the candidate index.
- The top holds the busy/owner/last_grant registers and the ready mux.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then all valid=0 -> s_ready_o=00 throughout.
2. Single requester, then packet lock:
   - number=0, m_ready=1, slave0 valid dest=0 -> s_ready_o=01 in the same cycle.
   - Slave1 then also requests dest=0 -> s_ready_o stays 01.
   - s_last=1 for one cycle -> next cycle s_ready_o=10.
   - Slave1 s_last=1 for one cycle -> s_ready_o=00 once slave1's valid drops.
3. Fairness: after slave1 owned last, both slaves valid with dest=0 simultaneously -> slave0 granted (01). After its last beat, slave1 is granted (10).
4. Destination filtering: number=1, slave0 dest=0, slave1 dest=1, both valid -> s_ready_o=10 only.
5. Back-pressure:
   - Owner slave0 with m_ready=0 -> s_ready_o=00.
   - s_last=1 while m_ready=0 does not release the lock.
   - m_ready=1 with s_last=1 -> release, and slave1 is granted next cycle.
6. Reset mid-packet: slave1 owns, rst pulse -> s_ready_o=00. Afterward, with both requesting, slave0 wins.
